// File: rtl/add4_pkg.sv
// Shared types and width constants for the add4 4-bit adder.
// Optional overflow output is enabled by defining ADD4_OVF_EN.
package add4_pkg;

  localparam int ADD4_W = 4;

  typedef logic [ADD4_W-1:0] nibble_t;

  typedef struct packed {
    logic    co;
    nibble_t s;
  } add4_res_t;

endpackage

// File: rtl/add4_full_adder.sv
// One-bit full adder; add4 chains four of these into a ripple-carry adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/add4.sv
// 4-bit ripple-carry adder a + b + ci -> {co, s}, optionally registered (REG_OUT).
// Defining ADD4_OVF_EN adds the ovf port: signed two's-complement overflow (c3 ^ c4).
module add4
  import add4_pkg::*;
#(
  parameter bit REG_OUT = 1'b1
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    in_valid,
  input  nibble_t a,
  input  nibble_t b,
  input  logic    ci,
  output nibble_t s,
  output logic    co,
`ifdef ADD4_OVF_EN
  output logic    ovf,
`endif
  output logic    out_valid
);

  logic [ADD4_W:0] w_c;
  nibble_t         w_sum;
  add4_res_t       w_res;

  assign w_c[0] = ci;

  for (genvar gi = 0; gi < ADD4_W; gi++) begin : g_fa
    full_adder u_fa (
      .a  (a[gi]),
      .b  (b[gi]),
      .ci (w_c[gi]),
      .s  (w_sum[gi]),
      .co (w_c[gi+1])
    );
  end

  assign w_res.co = w_c[ADD4_W];
  assign w_res.s  = w_sum;

`ifdef ADD4_OVF_EN
  logic w_ovf;
  // Overflow when the carry into the sign bit differs from the carry out of it.
  assign w_ovf = w_c[ADD4_W-1] ^ w_c[ADD4_W];
`endif

  if (REG_OUT) begin : g_reg
    add4_res_t r_res;
    logic      r_valid;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_res   <= '0;
        r_valid <= 1'b0;
      end else begin
        r_valid <= in_valid;
        if (in_valid) begin
          r_res <= w_res;
        end
      end
    end

`ifdef ADD4_OVF_EN
    logic r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_ovf <= 1'b0;
      end else if (in_valid) begin
        r_ovf <= w_ovf;
      end
    end

    assign ovf = r_ovf;
`endif

    assign s         = r_res.s;
    assign co        = r_res.co;
    assign out_valid = r_valid;
  end else begin : g_comb
    assign s         = w_res.s;
    assign co        = w_res.co;
    assign out_valid = in_valid;
`ifdef ADD4_OVF_EN
    assign ovf       = w_ovf;
`endif
  end

endmodule

// File: tb/tb_add4.sv
// Self-checking bench for add4: registered and combinational instances share stimulus.
// Build with ADD4_OVF_EN defined to also check the overflow output.
module tb_add4;
  import add4_pkg::*;

  logic    clk = 1'b0;
  logic    rst_n = 1'b0;
  logic    in_valid = 1'b0;
  nibble_t a = '0;
  nibble_t b = '0;
  logic    ci = 1'b0;

  nibble_t s_r, s_c;
  logic    co_r, co_c, v_r, v_c;
  logic    ovf_r, ovf_c;

`ifdef ADD4_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
  assign ovf_r = 1'b0;
  assign ovf_c = 1'b0;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  nibble_t e_s;
  logic    e_co, e_v, e_ovf;

  always #5 clk = ~clk;

  add4 #(.REG_OUT(1'b1)) u_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .ci        (ci),
    .s         (s_r),
    .co        (co_r),
`ifdef ADD4_OVF_EN
    .ovf       (ovf_r),
`endif
    .out_valid (v_r)
  );

  add4 #(.REG_OUT(1'b0)) u_comb (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .ci        (ci),
    .s         (s_c),
    .co        (co_c),
`ifdef ADD4_OVF_EN
    .ovf       (ovf_c),
`endif
    .out_valid (v_c)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Reference: plain unsigned and signed arithmetic, returns {ovf, co, s}.
  function automatic logic [5:0] ref_add(input nibble_t x, input nibble_t y, input logic c);
    int u, sx, sy, ss;
    logic o;
    u  = int'(x) + int'(y) + int'(c);
    sx = (x >= 8) ? int'(x) - 16 : int'(x);
    sy = (y >= 8) ? int'(y) - 16 : int'(y);
    ss = sx + sy + int'(c);
    o  = (ss > 7) || (ss < -8);
    return {o & OVF_ON, u[4:0]};
  endfunction

  task automatic check_reg(input string tag);
    check(tag, {1'b0, ovf_r, v_r, co_r, s_r}, {1'b0, e_ovf, e_v, e_co, e_s});
  endtask

  task automatic clear_model();
    e_s = '0; e_co = 1'b0; e_v = 1'b0; e_ovf = 1'b0;
  endtask

  // Drive one operand set at negedge; check comb path, hold before edge, result after edge.
  task automatic step(input string tag, input nibble_t xa, input nibble_t xb,
                      input logic xc, input logic xv);
    logic [5:0] r;
    @(negedge clk);
    a = xa; b = xb; ci = xc; in_valid = xv;
    r = ref_add(xa, xb, xc);
    #1;
    check({tag, "_pre_edge"}, {1'b0, ovf_r, v_r, co_r, s_r}, {1'b0, e_ovf, e_v, e_co, e_s});
    check({tag, "_comb"}, {1'b0, ovf_c, v_c, co_c, s_c}, {1'b0, r[5], xv, r[4:0]});
    if (xv) begin
      e_s = r[3:0]; e_co = r[4]; e_ovf = r[5];
    end
    e_v = xv;
    @(posedge clk);
    #1;
    check_reg({tag, "_reg"});
  endtask

  initial begin
    clear_model();

    // Held in reset with random valid inputs: outputs stay cleared.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a = nibble_t'($urandom_range(15)); b = nibble_t'($urandom_range(15));
      ci = 1'($urandom_range(1)); in_valid = 1'b1;
      @(posedge clk); #1;
      check_reg("reset_hold");
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;

    step("one_plus_one",  4'b0001, 4'b0001, 1'b0, 1'b1);
    step("one_one_ci",    4'b0001, 4'b0001, 1'b1, 1'b1);
    step("ripple_ci0",    4'b0111, 4'b1000, 1'b0, 1'b1);
    step("ripple_ci1",    4'b0111, 4'b1000, 1'b1, 1'b1);
    step("max_all",       4'b1111, 4'b1111, 1'b1, 1'b1);
    step("zero",          4'b0000, 4'b0000, 1'b0, 1'b1);
    step("signed_ovf",    4'b0111, 4'b0001, 1'b0, 1'b1);

    // Random stream of 16 back-to-back valid vectors, then idle cycles hold the result.
    for (int i = 0; i < 16; i++)
      step("stream", nibble_t'($urandom_range(15)), nibble_t'($urandom_range(15)),
           1'($urandom_range(1)), 1'b1);
    for (int i = 0; i < 3; i++)
      step("idle_hold", nibble_t'($urandom_range(15)), nibble_t'($urandom_range(15)),
           1'($urandom_range(1)), 1'b0);

    // Random mix of valid and idle cycles.
    for (int i = 0; i < 60; i++)
      step("rand_mix", nibble_t'($urandom_range(15)), nibble_t'($urandom_range(15)),
           1'($urandom_range(1)), 1'($urandom_range(1)));

    // Async reset mid-cycle, away from any clock edge, discards the held result.
    step("pre_reset", 4'b1010, 4'b0110, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    clear_model();
    #1;
    check_reg("async_reset_clear");
    @(posedge clk); #1;
    check_reg("async_reset_held");
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    step("post_reset", 4'b0011, 4'b0100, 1'b0, 1'b1);

    // Exhaustive sweep of all 512 operand combinations.
    for (int ia = 0; ia < 16; ia++)
      for (int ib = 0; ib < 16; ib++)
        for (int ic = 0; ic < 2; ic++)
          step("sweep", nibble_t'(ia), nibble_t'(ib), 1'(ic), 1'b1);

    // Unknown operands propagate to the sum and carry.
    @(negedge clk);
    a = 'x; b = 'x; ci = 1'bx; in_valid = 1'b1;
    #1;
    check("x_comb", {2'b00, OVF_ON ? ovf_c : 1'b0, co_c, s_c},
          {2'b00, OVF_ON ? 1'bx : 1'b0, 5'bxxxxx});
    @(posedge clk); #1;
    check("x_reg", {2'b00, OVF_ON ? ovf_r : 1'b0, co_r, s_r},
          {2'b00, OVF_ON ? 1'bx : 1'b0, 5'bxxxxx});
    check("x_reg_valid", {7'd0, v_r}, 8'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/add4.md
Name: add4

Overview:
- 4-bit ripple-carry adder with carry-in and carry-out: a + b + ci -> {co, s}.
- Result is registered: one clock of latency, one new operand set accepted per cycle, no stalls.
- Used as a leaf arithmetic block in the datapath and as the reference small adder for gate-level and RTL checks.

Parameters:
- REG_OUT, default 1: 1 = s/co/out_valid registered (latency 1); 0 = s/co purely combinational from a/b/ci, out_valid = in_valid combinationally, clk/rst_n unused.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands on a/b/ci are valid this cycle.
- a  input  4  addend, unsigned (bit 3 = MSB).
- b  input  4  addend, unsigned.
- ci  input  1  carry-in (weight 1).
- s  output  4  sum bits [3:0] of a+b+ci.
- co  output  1  carry-out (weight 16).
- out_valid  output  1  s/co hold the result of a valid operand set.

Behaviour:
- Arithmetic: {co, s} = a + b + ci, exact 5-bit result; range 0..31; no saturation; modulo-16 wrap on s with co carrying bit 4.
- Structure: four chained 1-bit full adders.
  - c0 = ci; c(i+1) = carry of stage i; co = c4.
  - s[i] = a[i] ^ b[i] ^ c(i).
  - carry = (a&b) | (a&c) | (b&c).
- REG_OUT=1:
  - On each rising clk edge with in_valid=1: s <= sum, co <= carry, out_valid <= 1.
  - On each rising clk edge with in_valid=0: out_valid <= 0; s and co hold their previous values.
  - Result appears exactly one cycle after the operands are sampled.
  - Back-to-back valid inputs produce back-to-back valid outputs.
- Reset: rst_n low forces s=0000, co=0, out_valid=0 immediately, independent of clk.
  - Release is synchronous to the next rising clk edge; the first capture occurs on the first rising edge with rst_n high.
  - Reset asserted mid-stream discards the in-flight result.
- Unknown inputs: X/Z on any operand bit produces X on dependent s/co bits in simulation. No X-masking logic.
- Boundary cases:
  - 1111+1111+1 = co 1, s 1111.
  - 0000+0000+0 = co 0, s 0000.
  - 0111+1000+1 = co 1, s 0000 (full carry ripple through all four stages).

Optional Feature:
- Macro ADD4_OVF_EN.
- Defined: extra output port ovf (1 bit) = signed two's-complement overflow = c3 ^ c4. Registered and reset to 0 exactly like co (combinational when REG_OUT=0).
- Not defined: no ovf port and no overflow logic.

Decomposition:
- Package add4_pkg:
  - localparam ADD4_W = 4.
  - typedef nibble_t = logic [3:0].
  - typedef add4_res_t = packed struct {co, s}.
- Sub-module full_adder (inputs a, b, ci; outputs s, co), instantiated four times via generate loop.
- Register stage lives in add4 itself.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> s=0000, co=0, out_valid=0. Assert rst_n asynchronously mid-cycle -> outputs clear without a clock edge.
- a=0001, b=0001, ci=0, in_valid=1 -> next cycle s=0010, co=0, out_valid=1. Same operands with ci=1 -> s=0011, co=0.
- a=0111, b=1000, ci=0 -> s=1111, co=0. Same operands with ci=1 -> s=0000, co=1 (full ripple). With ADD4_OVF_EN, ovf=0 in both cases.
- a=1111, b=1111, ci=1 -> s=1111, co=1. a=0111, b=0001, ci=0 with ADD4_OVF_EN -> s=1000, co=0, ovf=1.
- Stream 16 consecutive valid vectors, then drop in_valid -> each result appears 1 cycle after its operands; out_valid falls 1 cycle after in_valid falls; s/co hold.
- Exhaustive 512-vector sweep of a/b/ci against a+b+ci, for both REG_OUT=1 and REG_OUT=0. Drive a=xxxx, b=xxxx, ci=x -> s and co go X in simulation.
